// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: instruction bit positions, instruction type and jump decode.
package hack_pkg;

   localparam int WORD_W  = 16;

   localparam int INSTR_C = 15;
   localparam int COMP_A  = 12;
   localparam int COMP_HI = 11;
   localparam int COMP_LO = 6;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JMP_LT  = 2;
   localparam int JMP_EQ  = 1;
   localparam int JMP_GT  = 0;

   typedef enum logic {
      ITYPE_A = 1'b0,
      ITYPE_C = 1'b1
   } instr_type_e;

   // jmp is {lt, eq, gt}; positive means neither negative nor zero.
   function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
      return (jmp[JMP_LT] & ng) | (jmp[JMP_EQ] & zr) | (jmp[JMP_GT] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_pc.sv
// Hack program counter: reset beats load, load beats increment; increment wraps mod 2^PC_W.
module hack_pc
   import hack_pkg::*;
#(
   parameter int PC_W = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic [PC_W-1:0] load_val_i,
   input  logic            inc_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d = pc_q + PC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage feeding an external ALU; single-cycle, one instruction per run cycle.
// Optional HACK_CPU_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module hack_cpu_ctrl
   import hack_pkg::*;
#(
   parameter int PC_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_i,
   input  logic [WORD_W-1:0] instr_i,
   input  logic [WORD_W-1:0] inM_i,
   output logic [WORD_W-1:0] alu_x_o,
   output logic [WORD_W-1:0] alu_y_o,
   output logic              alu_zx_o,
   output logic              alu_nx_o,
   output logic              alu_zy_o,
   output logic              alu_ny_o,
   output logic              alu_f_o,
   output logic              alu_no_o,
   input  logic [WORD_W-1:0] alu_out_i,
   input  logic              alu_zr_i,
   input  logic              alu_ng_i,
   output logic [WORD_W-1:0] outM_o,
   output logic              writeM_o,
   output logic [14:0]       addressM_o,
   output logic [PC_W-1:0]   pc_o
`ifdef HACK_CPU_RETIRE_CNT_EN
   ,output logic [31:0]      retired_o
`endif
);

   logic [WORD_W-1:0] a_q, a_d;
   logic [WORD_W-1:0] d_q, d_d;
   instr_type_e       itype;
   logic              is_c;
   logic              jump;
   logic              unused_bits;

   assign itype       = instr_type_e'(instr_i[INSTR_C]);
   assign is_c        = (itype == ITYPE_C);
   assign unused_bits = ^instr_i[14:13];

   // Controls and operands are driven from the raw bits even for A-instructions.
   assign {alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o} = instr_i[COMP_HI:COMP_LO];
   assign alu_x_o = d_q;
   assign alu_y_o = instr_i[COMP_A] ? inM_i : a_q;

   assign outM_o     = alu_out_i;
   assign writeM_o   = is_c & instr_i[DEST_M] & run_i & rst_n;
   assign addressM_o = a_q[14:0];

   assign jump = is_c & jump_taken(instr_i[JMP_LT:JMP_GT], alu_zr_i, alu_ng_i);

   always_comb begin
      a_d = a_q;
      d_d = d_q;
      if (run_i) begin
         if (!is_c) begin
            a_d = instr_i;
         end else begin
            if (instr_i[DEST_A]) a_d = alu_out_i;
            if (instr_i[DEST_D]) d_d = alu_out_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q <= '0;
         d_q <= '0;
      end else begin
         a_q <= a_d;
         d_q <= d_d;
      end
   end

   // Jump target is the A value held before this edge's write-back.
   hack_pc #(
      .PC_W (PC_W)
   ) u_pc (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (run_i & jump),
      .load_val_i (a_q[PC_W-1:0]),
      .inc_i      (run_i),
      .pc_o       (pc_o)
   );

`ifdef HACK_CPU_RETIRE_CNT_EN
   logic [31:0] ret_q, ret_d;

   always_comb begin
      ret_d = ret_q;
      if (run_i) ret_d = ret_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ret_q <= '0;
      end else begin
         ret_q <= ret_d;
      end
   end

   assign retired_o = ret_q;
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed self-checking bench for hack_cpu_ctrl with a behavioural Hack ALU and small RAM.
module tb_hack_cpu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [15:0] instr;
   logic [15:0] inM;
   logic [15:0] alu_x, alu_y, alu_out;
   logic        zx, nx, zy, ny, f, no, alu_zr, alu_ng;
   logic [15:0] outM;
   logic        writeM;
   logic [14:0] addressM;
   logic [14:0] pc;
`ifdef HACK_CPU_RETIRE_CNT_EN
   logic [31:0] retired;
   logic [31:0] exp_ret;
`endif

   logic [15:0] ram [0:63];
   int n_pass;
   int n_total;

   hack_cpu_ctrl #(.PC_W(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_i      (run),
      .instr_i    (instr),
      .inM_i      (inM),
      .alu_x_o    (alu_x),
      .alu_y_o    (alu_y),
      .alu_zx_o   (zx),
      .alu_nx_o   (nx),
      .alu_zy_o   (zy),
      .alu_ny_o   (ny),
      .alu_f_o    (f),
      .alu_no_o   (no),
      .alu_out_i  (alu_out),
      .alu_zr_i   (alu_zr),
      .alu_ng_i   (alu_ng),
      .outM_o     (outM),
      .writeM_o   (writeM),
      .addressM_o (addressM),
      .pc_o       (pc)
`ifdef HACK_CPU_RETIRE_CNT_EN
      ,.retired_o (retired)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference Hack ALU
   logic [15:0] ax, ay, ao;
   always_comb begin
      ax = zx ? 16'h0000 : alu_x;
      if (nx) ax = ~ax;
      ay = zy ? 16'h0000 : alu_y;
      if (ny) ay = ~ay;
      ao = f ? (ax + ay) : (ax & ay);
      if (no) ao = ~ao;
   end
   assign alu_out = ao;
   assign alu_zr  = (ao == 16'h0000);
   assign alu_ng  = ao[15];

   assign inM = ram[addressM[5:0]];
   always @(posedge clk) begin
      if (writeM) ram[addressM[5:0]] <= outM;
   end

`ifdef HACK_CPU_RETIRE_CNT_EN
   always @(posedge clk) begin
      if (!rst_n) exp_ret <= 32'd0;
      else if (run) exp_ret <= exp_ret + 32'd1;
   end
`endif

   task automatic step(input logic [15:0] ins);
      instr = ins;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      run   = 1'b1;
      instr = 16'($urandom);
      @(posedge clk); #1;
      instr = 16'hE308;
      #1;
      n_total++;
      if (writeM !== 1'b0) $display("FAIL reset_writeM_forced got=%b exp=0", writeM); else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (pc !== 15'h0000) $display("FAIL reset_pc got=%h exp=0000", pc); else n_pass++;
      n_total++;
      if (addressM !== 15'h0000) $display("FAIL reset_A got=%h exp=0000", addressM); else n_pass++;
      n_total++;
      if (alu_x !== 16'h0000) $display("FAIL reset_D got=%h exp=0000", alu_x); else n_pass++;
`ifdef HACK_CPU_RETIRE_CNT_EN
      n_total++;
      if (retired !== 32'd0) $display("FAIL reset_retired got=%0d exp=0", retired); else n_pass++;
`endif
      instr = 16'h0000;
      rst_n = 1'b1;
   endtask

   task automatic test_load_a_d();
      step(16'h0003);
      n_total++;
      if (addressM !== 15'h0003 || pc !== 15'h0001)
         $display("FAIL at3 A=%h pc=%h exp A=0003 pc=0001", addressM, pc); else n_pass++;
      step(16'hEC10);
      n_total++;
      if (alu_x !== 16'h0003 || pc !== 15'h0002)
         $display("FAIL d_eq_a D=%h pc=%h exp D=0003 pc=0002", alu_x, pc); else n_pass++;
   endtask

   task automatic test_add_store();
      step(16'h0005);
      step(16'hE090);
      n_total++;
      if (alu_x !== 16'h0008 || pc !== 15'h0004)
         $display("FAIL d_plus_a D=%h pc=%h exp D=0008 pc=0004", alu_x, pc); else n_pass++;
      step(16'h0010);
      instr = 16'hE308;
      #1;
      n_total++;
      if (writeM !== 1'b1 || addressM !== 15'h0010 || outM !== 16'h0008)
         $display("FAIL m_eq_d wr=%b addr=%h out=%h exp wr=1 addr=0010 out=0008", writeM, addressM, outM);
      else n_pass++;
      @(posedge clk); #1;
      instr = 16'h0020;
      #1;
      n_total++;
      if (ram[16] !== 16'h0008 || writeM !== 1'b0 || pc !== 15'h0006)
         $display("FAIL m_store ram=%h wr=%b pc=%h exp ram=0008 wr=0 pc=0006", ram[16], writeM, pc);
      else n_pass++;
   endtask

   task automatic test_jump();
      step(16'h0020);
      step(16'hE301);
      n_total++;
      if (pc !== 15'h0020) $display("FAIL jgt_taken pc=%h exp=0020", pc); else n_pass++;
      step(16'hEA90);
      step(16'hE301);
      n_total++;
      if (pc !== 15'h0022) $display("FAIL jgt_zero_not_taken pc=%h exp=0022", pc); else n_pass++;
      step(16'hEE90);
      n_total++;
      if (alu_x !== 16'hFFFF) $display("FAIL d_minus1 D=%h exp=FFFF", alu_x); else n_pass++;
      step(16'hE304);
      n_total++;
      if (pc !== 15'h0020) $display("FAIL jlt_taken pc=%h exp=0020", pc); else n_pass++;
      step(16'hE301);
      n_total++;
      if (pc !== 15'h0021) $display("FAIL jgt_neg_not_taken pc=%h exp=0021", pc); else n_pass++;
      // A=D+1;JMP must jump to the old A while A itself becomes 0
      step(16'hE7E7);
      n_total++;
      if (pc !== 15'h0020 || addressM !== 15'h0000)
         $display("FAIL jmp_old_a pc=%h A=%h exp pc=0020 A=0000", pc, addressM); else n_pass++;
   endtask

   task automatic test_wrap();
      step(16'h7FFF);
      step(16'hEA87);
      n_total++;
      if (pc !== 15'h7FFF) $display("FAIL jmp_7fff pc=%h exp=7fff", pc); else n_pass++;
      step(16'h0000);
      n_total++;
      if (pc !== 15'h0000 || addressM !== 15'h0000)
         $display("FAIL pc_wrap pc=%h A=%h exp pc=0000 A=0000", pc, addressM); else n_pass++;
   endtask

   task automatic test_freeze();
      step(16'h0005);
      run   = 1'b0;
      instr = 16'hE7D8;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_total++;
         if (writeM !== 1'b0 || outM !== 16'h0000)
            $display("FAIL freeze_comb%0d wr=%b out=%h exp wr=0 out=0000", i, writeM, outM);
         else n_pass++;
         @(posedge clk); #1;
         n_total++;
         if (pc !== 15'h0001 || addressM !== 15'h0005 || alu_x !== 16'hFFFF)
            $display("FAIL freeze_hold%0d pc=%h A=%h D=%h exp pc=0001 A=0005 D=ffff", i, pc, addressM, alu_x);
         else n_pass++;
      end
`ifdef HACK_CPU_RETIRE_CNT_EN
      n_total++;
      if (retired !== exp_ret) $display("FAIL retired_freeze got=%0d exp=%0d", retired, exp_ret); else n_pass++;
`endif
      run = 1'b1;
   endtask

   task automatic test_reset_mid();
      step(16'hEA90);
      instr = 16'hE7D8;
      #1;
      n_total++;
      if (writeM !== 1'b1 || outM !== 16'h0001)
         $display("FAIL amd_pre wr=%b out=%h exp wr=1 out=0001", writeM, outM); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (writeM !== 1'b0) $display("FAIL reset_mid_wr got=%b exp=0", writeM); else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (pc !== 15'h0000 || addressM !== 15'h0000 || alu_x !== 16'h0000 || ram[5] !== 16'h1234)
         $display("FAIL reset_mid pc=%h A=%h D=%h ram5=%h exp 0000 0000 0000 1234", pc, addressM, alu_x, ram[5]);
      else n_pass++;
`ifdef HACK_CPU_RETIRE_CNT_EN
      n_total++;
      if (retired !== 32'd0) $display("FAIL retired_reset_mid got=%0d exp=0", retired); else n_pass++;
`endif
      rst_n = 1'b1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      for (int i = 0; i < 64; i++) ram[i] = 16'h0000;
      ram[5] = 16'h1234;
      rst_n  = 1'b0;
      run    = 1'b1;
      instr  = 16'h0000;
      #2;
      test_reset();
      test_load_a_d();
      test_add_store();
      test_jump();
      test_wrap();
      test_freeze();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
